// File: rtl/sha3_miner_csr_pkg.sv
// Shared address map, control bit positions and ID constant for the SHA3 miner CSR block.
package sha3_miner_pkg;
    localparam int ADDR_HEADER   = 'h00;
    localparam int ADDR_DIFF     = 'h08;
    localparam int ADDR_NONCE_LO = 'h10;
    localparam int ADDR_NONCE_HI = 'h11;
    localparam int ADDR_CTRL     = 'h12;
    localparam int ADDR_STATUS   = 'h13;
    localparam int ADDR_SOL_LO   = 'h14;
    localparam int ADDR_SOL_HI   = 'h15;
    localparam int ADDR_IRQ_EN   = 'h16;
    localparam int ADDR_IRQ_PEND = 'h17;
    localparam int ADDR_CNT_LO   = 'h18;
    localparam int ADDR_CNT_HI   = 'h19;
    localparam int ADDR_ID       = 'h1F;

    localparam int RUN      = 0;
    localparam int TEST     = 1;
    localparam int HALT     = 2;
    localparam int PADL_LSB = 3;
    localparam int PADF_LSB = 11;

    localparam logic [31:0] ID_VALUE = 32'h5348_4133;
endpackage

// File: rtl/sha3_miner_csr_wide_reg.sv
// Byte-enabled, lockable register built from 32-bit word slices at a contiguous word range.
module csr_wide_reg #(
    parameter int ADDR_W = 5,
    parameter int BASE   = 0,
    parameter int WORDS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_write,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_be,
    input  logic                  i_lock,
    output logic [32*WORDS-1:0]   o_q,
    output logic [31:0]           o_rdata,
    output logic                  o_hit
);
    logic [32*WORDS-1:0] r_q;
    logic [WORDS-1:0]    w_sel;

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < WORDS; k++) begin
            w_sel[k] = (i_address == ADDR_W'(BASE + k));
            if (w_sel[k]) o_rdata = r_q[32*k +: 32];
        end
    end

    assign o_hit = |w_sel;
    assign o_q   = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_write && !i_lock) begin
            for (int k = 0; k < WORDS; k++)
                for (int b = 0; b < 4; b++)
                    if (w_sel[k] && i_be[b]) r_q[32*k + 8*b +: 8] <= i_wdata[8*b +: 8];
        end
    end
endmodule

// File: rtl/sha3_miner_csr.sv
// Avalon-MM CSR block feeding the SHA3-256 miner; captures solutions and raises a sticky IRQ.
// Optional hash counter at 0x18/0x19 is built only when SHA3_MINER_CSR_HASHCNT_EN is defined.
module sha3_miner_csr
    import sha3_miner_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] ID_VALUE = sha3_miner_pkg::ID_VALUE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [255:0]      header,
    output logic [255:0]      difficulty,
    output logic [63:0]       start_nonce,
    output logic [18:0]       control,
    input  logic [63:0]       miner_solution,
    input  logic [6:0]        miner_status,
    input  logic              miner_irq,
    output logic              irq
);
    logic [18:0] r_control;
    logic        r_wr_err, r_pending, r_irq_en, r_irq, r_miner_irq_d;
    logic [63:0] r_sol;
    logic [31:0] r_sol_hi_snap, r_rdata;
    logic        r_rdvalid;

    logic [31:0] w_hdr_rdata, w_diff_rdata, w_nonce_rdata, w_rdata;
    logic        w_hdr_hit, w_diff_hit, w_nonce_hit;
    logic        w_rd, w_rise, w_locked_wr;
    logic        w_wr_ctrl, w_wr_irq_en, w_wr_pend, w_rd_sol_lo;

    // Simultaneous read+write is treated as a write only.
    assign w_rd        = avs_read && !avs_write;
    assign w_rise      = miner_irq && !r_miner_irq_d;
    assign w_locked_wr = avs_write && r_control[RUN] && (w_hdr_hit || w_diff_hit || w_nonce_hit);
    assign w_wr_ctrl   = avs_write && (avs_address == ADDR_W'(ADDR_CTRL));
    assign w_wr_irq_en = avs_write && (avs_address == ADDR_W'(ADDR_IRQ_EN));
    assign w_wr_pend   = avs_write && (avs_address == ADDR_W'(ADDR_IRQ_PEND)) && avs_byteenable[0];
    assign w_rd_sol_lo = w_rd && (avs_address == ADDR_W'(ADDR_SOL_LO));

    csr_wide_reg #(.ADDR_W(ADDR_W), .BASE(ADDR_HEADER), .WORDS(8)) u_header (
        .clk(clk), .rst_n(rst_n), .i_write(avs_write), .i_address(avs_address),
        .i_wdata(avs_writedata), .i_be(avs_byteenable), .i_lock(r_control[RUN]),
        .o_q(header), .o_rdata(w_hdr_rdata), .o_hit(w_hdr_hit));

    csr_wide_reg #(.ADDR_W(ADDR_W), .BASE(ADDR_DIFF), .WORDS(8)) u_difficulty (
        .clk(clk), .rst_n(rst_n), .i_write(avs_write), .i_address(avs_address),
        .i_wdata(avs_writedata), .i_be(avs_byteenable), .i_lock(r_control[RUN]),
        .o_q(difficulty), .o_rdata(w_diff_rdata), .o_hit(w_diff_hit));

    csr_wide_reg #(.ADDR_W(ADDR_W), .BASE(ADDR_NONCE_LO), .WORDS(2)) u_nonce (
        .clk(clk), .rst_n(rst_n), .i_write(avs_write), .i_address(avs_address),
        .i_wdata(avs_writedata), .i_be(avs_byteenable), .i_lock(r_control[RUN]),
        .o_q(start_nonce), .o_rdata(w_nonce_rdata), .o_hit(w_nonce_hit));

`ifdef SHA3_MINER_CSR_HASHCNT_EN
    logic [63:0] r_hash_cnt;
    logic [31:0] r_cnt_hi_snap;
    logic        w_run_start;

    assign w_run_start = w_wr_ctrl && avs_byteenable[0] && avs_writedata[RUN] && !r_control[RUN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hash_cnt    <= '0;
            r_cnt_hi_snap <= '0;
        end else begin
            if (w_run_start)
                r_hash_cnt <= '0;
            else if (r_control[RUN] && !miner_irq && (r_hash_cnt != '1))
                r_hash_cnt <= r_hash_cnt + 64'd1;
            if (w_rd && (avs_address == ADDR_W'(ADDR_CNT_LO)))
                r_cnt_hi_snap <= r_hash_cnt[63:32];
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (w_hdr_hit)   w_rdata = w_hdr_rdata;
        if (w_diff_hit)  w_rdata = w_diff_rdata;
        if (w_nonce_hit) w_rdata = w_nonce_rdata;
        case (avs_address)
            ADDR_W'(ADDR_CTRL):     w_rdata = {13'd0, r_control};
            ADDR_W'(ADDR_STATUS):   w_rdata = {23'd0, r_wr_err, r_pending, miner_status};
            ADDR_W'(ADDR_SOL_LO):   w_rdata = r_sol[31:0];
            ADDR_W'(ADDR_SOL_HI):   w_rdata = r_sol_hi_snap;
            ADDR_W'(ADDR_IRQ_EN):   w_rdata = {31'd0, r_irq_en};
            ADDR_W'(ADDR_IRQ_PEND): w_rdata = {30'd0, r_wr_err, r_pending};
`ifdef SHA3_MINER_CSR_HASHCNT_EN
            ADDR_W'(ADDR_CNT_LO):   w_rdata = r_hash_cnt[31:0];
            ADDR_W'(ADDR_CNT_HI):   w_rdata = r_cnt_hi_snap;
`endif
            ADDR_W'(ADDR_ID):       w_rdata = ID_VALUE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_control     <= '0;
            r_wr_err      <= 1'b0;
            r_pending     <= 1'b0;
            r_irq_en      <= 1'b0;
            r_irq         <= 1'b0;
            r_miner_irq_d <= 1'b0;
            r_sol         <= '0;
            r_sol_hi_snap <= '0;
            r_rdata       <= '0;
            r_rdvalid     <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                if (avs_byteenable[0]) r_control[7:0]   <= avs_writedata[7:0];
                if (avs_byteenable[1]) r_control[15:8]  <= avs_writedata[15:8];
                if (avs_byteenable[2]) r_control[18:16] <= avs_writedata[18:16];
            end
            if (w_wr_irq_en && avs_byteenable[0]) r_irq_en <= avs_writedata[0];
            // Set beats W1C when both land in the same cycle.
            if (w_locked_wr)                              r_wr_err <= 1'b1;
            else if (w_wr_pend && avs_writedata[1])       r_wr_err <= 1'b0;
            if (w_rise)                                   r_pending <= 1'b1;
            else if (w_wr_pend && avs_writedata[0])       r_pending <= 1'b0;
            if (w_rise) r_sol <= miner_solution;
            r_miner_irq_d <= miner_irq;
            r_irq         <= r_pending && r_irq_en;
            if (w_rd_sol_lo) r_sol_hi_snap <= r_sol[63:32];
            r_rdvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
        end
    end

    assign control           = r_control;
    assign irq               = r_irq;
    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rdvalid;
endmodule

// File: tb/tb_sha3_miner_csr.sv
// Directed bench for sha3_miner_csr: register access, write lock, solution capture and IRQ.
module tb_sha3_miner_csr;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   avs_address = '0;
    logic         avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0]  avs_writedata = '0;
    logic [3:0]   avs_byteenable = '0;
    logic [31:0]  avs_readdata;
    logic         avs_readdatavalid;
    logic [255:0] header, difficulty;
    logic [63:0]  start_nonce;
    logic [18:0]  control;
    logic [63:0]  miner_solution = '0;
    logic [6:0]   miner_status = '0;
    logic         miner_irq = 1'b0;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    sha3_miner_csr dut (
        .clk(clk), .rst_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .header(header), .difficulty(difficulty), .start_nonce(start_nonce), .control(control),
        .miner_solution(miner_solution), .miner_status(miner_status), .miner_irq(miner_irq),
        .irq(irq));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        avs_address = addr; avs_writedata = data; avs_byteenable = be; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr; avs_read = 1'b1;
        @(posedge clk); #1;
        check_eq("rdvalid", 64'(avs_readdatavalid), 64'd1);
        data = avs_readdata;
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_readdata", 64'(avs_readdata), 64'd0);
        check_eq("rst_rdvalid", 64'(avs_readdatavalid), 64'd0);
        check_eq("rst_irq", 64'(irq), 64'd0);
        check_eq("rst_control", 64'(control), 64'd0);
        check_eq("rst_nonce", start_nonce, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        do_read(5'h1F, rd); check_eq("id", 64'(rd), 64'h5348_4133);
        @(posedge clk); #1;
        check_eq("rdvalid_single", 64'(avs_readdatavalid), 64'd0);
        miner_status = 7'h41;
        do_read(5'h13, rd); check_eq("status_init", 64'(rd), 64'h41);

        do_write(5'h00, 32'hDEAD_BEEF, 4'b0011);
        check_eq("hdr_w0_be", 64'(header[31:0]), 64'h0000_BEEF);
        check_eq("hdr_upper", 64'(header[255:224]), 64'd0);
        do_write(5'h11, 32'h1, 4'hF);
        check_eq("nonce_hi", start_nonce, 64'h1_0000_0000);

        // Write lock while running
        do_write(5'h12, 32'h1, 4'hF);
        check_eq("ctrl_run", 64'(control), 64'h1);
        do_write(5'h08, 32'hFFFF_FFFF, 4'hF);
        check_eq("diff_locked", 64'(difficulty[31:0]), 64'd0);
        do_read(5'h13, rd); check_eq("status_wr_err", 64'(rd), 64'h141);
        do_write(5'h17, 32'h2, 4'hF);
        do_read(5'h13, rd); check_eq("status_err_clr", 64'(rd), 64'h41);

        // Solution capture and interrupt
        do_write(5'h16, 32'h1, 4'hF);
        @(negedge clk);
        miner_solution = 64'h0000_0012_3456_789A; miner_irq = 1'b1;
        @(posedge clk); #1;
        check_eq("irq_lag", 64'(irq), 64'd0);
        @(posedge clk); #1;
        check_eq("irq_set", 64'(irq), 64'd1);
        do_read(5'h14, rd); check_eq("sol_lo", 64'(rd), 64'h3456_789A);
        miner_solution = 64'hFFFF_FFFF_FFFF_FFFF;
        do_read(5'h15, rd); check_eq("sol_hi_snap", 64'(rd), 64'h12);
        do_read(5'h13, rd); check_eq("status_pend", 64'(rd), 64'hC1);

        // W1C colliding with a new rising edge: set wins
        @(negedge clk) miner_irq = 1'b0;
        @(negedge clk);
        miner_irq = 1'b1;
        avs_address = 5'h17; avs_writedata = 32'h1; avs_byteenable = 4'hF; avs_write = 1'b1;
        @(negedge clk) avs_write = 1'b0;
        do_read(5'h13, rd); check_eq("pend_set_wins", 64'(rd), 64'hC1);
        do_write(5'h17, 32'h1, 4'hF);
        check_eq("irq_hold", 64'(irq), 64'd1);
        @(posedge clk); #1;
        check_eq("irq_clr", 64'(irq), 64'd0);
        do_read(5'h13, rd); check_eq("pend_clr", 64'(rd), 64'h41);

        // Run deassert keeps the solution; unlocked writes land again
        do_write(5'h12, 32'h0, 4'hF);
        do_read(5'h14, rd); check_eq("sol_kept_lo", 64'(rd), 64'hFFFF_FFFF);
        do_read(5'h15, rd); check_eq("sol_kept_hi", 64'(rd), 64'hFFFF_FFFF);
        do_write(5'h01, 32'h1234_5678, 4'hF);
        check_eq("hdr_w1", 64'(header[63:32]), 64'h1234_5678);
        do_read(5'h01, rd); check_eq("hdr_w1_rd", 64'(rd), 64'h1234_5678);

        // Read+write together: write only
        @(negedge clk);
        avs_address = 5'h16; avs_writedata = 32'h0; avs_byteenable = 4'hF;
        avs_read = 1'b1; avs_write = 1'b1;
        @(posedge clk); #1;
        check_eq("rw_no_valid", 64'(avs_readdatavalid), 64'd0);
        @(negedge clk) begin avs_read = 1'b0; avs_write = 1'b0; end
        do_read(5'h16, rd); check_eq("irq_en_wr", 64'(rd), 64'd0);
        do_read(5'h1A, rd); check_eq("unmapped", 64'(rd), 64'd0);
        do_read(5'h11, rd); check_eq("nonce_rd", 64'(rd), 64'h1);

`ifdef SHA3_MINER_CSR_HASHCNT_EN
        @(negedge clk) miner_irq = 1'b0;
        do_write(5'h12, 32'h1, 4'hF);
        repeat (98) @(negedge clk);
        do_write(5'h12, 32'h0, 4'hF);
        do_read(5'h18, rd); check_eq("cnt_lo", 64'(rd), 64'd100);
        do_read(5'h19, rd); check_eq("cnt_hi", 64'(rd), 64'd0);
        do_write(5'h12, 32'h1, 4'hF);
        repeat (5) @(negedge clk);
`else
        do_read(5'h18, rd); check_eq("cnt_absent", 64'(rd), 64'd0);
`endif

        // Reset in the middle of a read with irq asserted
        do_write(5'h16, 32'h1, 4'hF);
        @(negedge clk) miner_irq = 1'b0;
        @(negedge clk) miner_irq = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_eq("irq_pre_rst", 64'(irq), 64'd1);
        @(negedge clk);
        avs_address = 5'h1F; avs_read = 1'b1;
        @(posedge clk); #1;
        check_eq("rdvalid_pre_rst", 64'(avs_readdatavalid), 64'd1);
        rst_n = 1'b0; avs_read = 1'b0; miner_irq = 1'b0;
        #1;
        check_eq("rst_mid_rdvalid", 64'(avs_readdatavalid), 64'd0);
        check_eq("rst_mid_irq", 64'(irq), 64'd0);
        check_eq("rst_mid_rdata", 64'(avs_readdata), 64'd0);
        check_eq("rst_mid_hdr", 64'(header[63:32]), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        do_read(5'h18, rd); check_eq("cnt_after_rst", 64'(rd), 64'd0);
        do_read(5'h13, rd); check_eq("status_after_rst", 64'(rd), 64'h41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sha3_miner_csr.md
Name: sha3_miner_csr

Overview:
- Avalon-MM slave register block sitting directly upstream of the SHA3-256 mining engine.
- HPS software programs header, difficulty, start nonce and control through this block; the block drives them to the engine.
- Captures the engine's solution and status on a found-solution event and raises a maskable, sticky interrupt to the HPS.

Parameters:
- ADDR_W, 5, word-address width (32 words).
- ID_VALUE, 32'h5348_4133, constant returned by the ID register.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte lanes for writes.
- avs_readdata  out  32  read data, registered.
- avs_readdatavalid  out  1  read response strobe.
- header  out  256  to engine.
- difficulty  out  256  to engine.
- start_nonce  out  64  to engine.
- control  out  19  to engine: {padf[7:0], padl[7:0], halt, test, run}.
- miner_solution  in  64  from engine.
- miner_status  in  7  from engine.
- miner_irq  in  1  engine match/halt flag, level.
- irq  out  1  interrupt to HPS.

Behaviour:
- Address map (words):
  - 0x00–0x07 header; word k = bits 32k+31:32k.
  - 0x08–0x0F difficulty, same layout.
  - 0x10/0x11 start_nonce lo/hi.
  - 0x12 control[18:0].
  - 0x13 STATUS (RO): {wr_err[8], pending[7], miner_status[6:0]}.
  - 0x14/0x15 SOL lo/hi (RO).
  - 0x16 IRQ_EN bit0.
  - 0x17 IRQ_PEND: W1C bit0, W1C bit1 = wr_err.
  - 0x18/0x19 hash counter (optional).
  - 0x1F ID.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset (async, rst_n=0): all registers and outputs are 0, including avs_readdata, avs_readdatavalid, irq, pending, wr_err and snapshots.
- Writes take effect at the clock edge where avs_write=1, with per-byte enables.
- Write lock:
  - While control[0] (run)=1, writes to 0x00–0x11 are dropped and set sticky wr_err.
  - Writes to control are always accepted.
- Reads:
  - Fixed latency 1: avs_readdata and avs_readdatavalid are valid exactly one cycle after avs_read.
  - avs_readdatavalid is 1 for one cycle per read.
  - Simultaneous avs_read and avs_write is illegal; the write wins and no readdatavalid is produced.
- Solution capture:
  - A rising edge on miner_irq (registered previous value 0, current value 1) loads sol_r<=miner_solution and sets pending.
  - On the same edge, if auto-stop is set (control bit run only; no extra bit), run is NOT cleared; software owns run.
- SOL atomic read:
  - Reading 0x14 returns sol_r[31:0] and latches sol_hi_snap<=sol_r[63:32].
  - Reading 0x15 returns sol_hi_snap.
- Interrupt:
  - irq = pending & irq_en, registered (one cycle after pending/enable change).
  - W1C clear and a new rising edge in the same cycle: set wins.
- Run deassert: writing run=0 does not clear pending or sol_r.
- Reset mid-read: the outstanding readdatavalid is suppressed.

Optional Feature:
- Macro SHA3_MINER_CSR_HASHCNT_EN.
- Defined:
  - 64-bit counter increments every cycle with control[0]=1 and miner_irq=0.
  - Clears on the run 0→1 write.
  - Reading 0x18 returns the low word and latches the high word; reading 0x19 returns the latched high word.
  - Saturates at all-ones.
- Undefined: 0x18/0x19 read 0 and no counter logic is built.

Decomposition:
- Package sha3_miner_pkg:
  - address constants (ADDR_HEADER=0x00, ADDR_DIFF=0x08, ADDR_NONCE_LO=0x10, ADDR_CTRL=0x12, ADDR_STATUS=0x13, ADDR_SOL_LO=0x14, ADDR_IRQ_EN=0x16, ADDR_IRQ_PEND=0x17, ADDR_CNT_LO=0x18, ADDR_ID=0x1F).
  - control bit indices (RUN=0, TEST=1, HALT=2, PADL_LSB=3, PADF_LSB=11).
  - ID_VALUE.
- One sub-module, csr_wide_reg: a byte-enabled, lockable 32-bit-sliced register used for header, difficulty and nonce.

Test Plan:
- Reset then read 0x1F → readdatavalid one cycle later, data 32'h53484133. Read 0x13 with miner_status=7'h41 → 32'h00000041.
- Write 0x00=32'hDEADBEEF with byteenable 4'b0011 → header[31:0]=32'h0000BEEF. Write 0x11=32'h1 → start_nonce=64'h1_0000_0000.
- Write control=19'h1 (run), then write 0x08=32'hFFFFFFFF → difficulty unchanged at 0, STATUS bit8=1. Write IRQ_PEND=2 → bit8=0.
- IRQ_EN=1, miner_solution=64'h0000_0012_3456_789A, pulse miner_irq 0→1 → pending=1, irq=1 next cycle. Read 0x14 → 32'h3456789A; change miner_solution; read 0x15 → 32'h00000012.
- W1C 0x17=1 in the same cycle as a new miner_irq rising edge → pending stays 1. Next W1C with no edge → pending=0, irq=0 one cycle later.
- With SHA3_MINER_CSR_HASHCNT_EN: run for 100 cycles with miner_irq=0 → 0x18 reads 100, 0x19 reads 0. Assert rst_n=0 mid-count → counter 0 and irq 0 immediately.
